seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider for the CPU's DIV/DIVU path; one quotient bit per cycle.
- Supports signed and unsigned operation, start/busy/done handshake, divide-by-zero flag and defined results for all corner cases.
- Sits beside the multiplier in the execute stage; control FSM pulses start and stalls until done.

---
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for the DIV/DIVU path: one quotient bit per cycle,
// signed/unsigned operation, start/busy/done handshake and divide-by-zero reporting.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             dz_r;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        if (en) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    // Trial subtraction keeps the partial remainder's MSB so divisors >= 2^(WIDTH-1) divide correctly
    always_comb begin
        trial_s = {rem_r, q_r[WIDTH-1]} - {1'b0, d_r};
        q_fix_s = neg_if(q_r, neg_q_r);
        r_fix_s = neg_if(rem_r, neg_r_r);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dz_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        neg_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_r <= is_signed & dividend[WIDTH-1];
                        d_r     <= abs_op(divisor, is_signed);
                        cnt_r   <= CNT_W'(WIDTH - 1);
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Raw dividend parked in rem_r becomes the reported remainder
                            dz_r    <= 1'b1;
                            rem_r   <= dividend;
                            q_r     <= {WIDTH{1'b0}};
                            state_r <= ST_FIX;
                        end else begin
                            dz_r    <= 1'b0;
                            rem_r   <= {WIDTH{1'b0}};
                            q_r     <= abs_op(dividend, is_signed);
                            state_r <= ST_RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!trial_s[WIDTH]) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        q_r   <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
                        q_r   <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (dz_r) begin
                        quotient  <= {WIDTH{1'b1}};
                        remainder <= rem_r;
                    end else begin
                        quotient  <= q_fix_s;
                        remainder <= r_fix_s;
                    end
                    div_by_zero <= dz_r;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider: a WIDTH=32 and a WIDTH=8 instance
// share clock and reset; hand sequences cover the handshake and reset corners.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start, is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    logic        start8, signed8;
    logic [7:0]  dividend8, divisor8;
    logic        busy8, done8, dz8;
    logic [7:0]  quotient8, remainder8;

    int tests  = 0;
    int failed = 0;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(signed8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8), .div_by_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          w8;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch from a negedge; returns at the negedge of the cycle in which done is seen.
    task automatic run_div(input string name, input bit w8, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat, input int mid);
        int          c;
        bit          busy_ok;
        logic        adone, abusy, adz;
        logic [31:0] aq, ar;
        busy_ok = 1'b1;
        adone   = 1'b0;
        if (w8) begin
            start8 = 1'b1; signed8 = sg; dividend8 = a[7:0]; divisor8 = b[7:0];
        end else begin
            start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        end
        @(posedge clk);
        #1;
        start = 1'b0; start8 = 1'b0;
        dividend = 32'hdead_beef; divisor = 32'h0000_0003;
        dividend8 = 8'h5a; divisor8 = 8'h03;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (mid > 0 && c == mid) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            adone = w8 ? done8 : done;
            abusy = w8 ? busy8 : busy;
            if (adone) break;
            if (!abusy) busy_ok = 1'b0;
        end
        start = 1'b0;
        aq  = w8 ? {24'd0, quotient8}  : quotient;
        ar  = w8 ? {24'd0, remainder8} : remainder;
        adz = w8 ? dz8 : div_by_zero;
        check({name, ".latency"}, 64'(c), 64'(elat));
        check({name, ".busy_during"}, 64'(busy_ok), 64'd1);
        check({name, ".busy_at_done"}, 64'(abusy), 64'd0);
        check({name, ".quotient"}, 64'(aq), 64'(eq));
        check({name, ".remainder"}, 64'(ar), 64'(er));
        check({name, ".div_by_zero"}, 64'(adz), 64'(edz));
    endtask

    initial begin
        bit never_done;

        vecs[0]  = '{"u_100_7",      1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};
        vecs[1]  = '{"s_m7_2",       1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
        vecs[2]  = '{"s_7_m2",       1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 34};
        vecs[3]  = '{"u_max_16",     1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         1'b0, 34};
        vecs[4]  = '{"u_5_0",        1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2};
        vecs[5]  = '{"s_5_0",        1'b0, 1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2};
        vecs[6]  = '{"s_min_m1",     1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 34};
        vecs[7]  = '{"s_m5_0",       1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2};
        vecs[8]  = '{"u_max_bigdiv", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0, 34};
        vecs[9]  = '{"s_m100_m7",    1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 34};
        vecs[10] = '{"w8_200_9",     1'b1, 1'b0, 32'd200,       32'd9,         32'd22,        32'd2,         1'b0, 10};
        vecs[11] = '{"w8_min_m1",    1'b1, 1'b1, 32'h80,        32'hFF,        32'h80,        32'd0,         1'b0, 10};
        vecs[12] = '{"w8_83_0",      1'b1, 1'b0, 32'h83,        32'd0,         32'hFF,        32'h83,        1'b1, 2};

        reset = 1'b1;
        start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        start8 = 1'b0; signed8 = 1'b0; dividend8 = 8'd0; divisor8 = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        check("reset.w8_quotient", 64'(quotient8), 64'd0);

        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].name, vecs[i].w8, vecs[i].sg, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 0);
            @(negedge clk);
            check({vecs[i].name, ".done_pulse"}, 64'(vecs[i].w8 ? done8 : done), 64'd0);
        end

        // A second start at cycle 10 of a run must not disturb the result
        run_div("mid_start", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 10);
        @(negedge clk);

        // Start held in the DONE cycle is ignored; start in the following idle cycle is taken
        run_div("b2b_first", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
        @(negedge clk);
        check("b2b.done_cycle_start_ignored", 64'(busy), 64'd0);
        check("b2b.done_dropped", 64'(done), 64'd0);
        run_div("b2b_second", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, 0);
        @(negedge clk);

        // Reset at RUN cycle 15 aborts immediately and suppresses done
        start = 1'b1; is_signed = 1'b0; dividend = 32'd200; divisor = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_mid.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        check("rst_mid.quotient", 64'(quotient), 64'd0);
        check("rst_mid.remainder", 64'(remainder), 64'd0);
        check("rst_mid.div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        never_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) never_done = 1'b0;
        end
        check("rst_mid.no_done_after", 64'(never_done), 64'd1);
        run_div("rst_mid_fresh", 1'b0, 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 34, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
